load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Memory-access stage directly downstream of ALU_nbit: takes the ALU result as the
//  effective address and performs RV32I loads/stores (LB/LH/LW/LBU/LHU/SB/SH/SW)
//  against a word-wide data memory over a req/ack handshake.
//  Generates byte enables, aligns store data, and sign/zero-extends load data.
//  Holds the core in stall through busy while an access is outstanding.
//  Flags misaligned or illegal accesses and memory timeouts.
// PARAMETERS
//  n        32  data/address width (fixed at 32: four byte lanes)
//  WAIT_MAX 15  max cycles in REQ without m_ack before bus error
//  CW       4   wait-counter width; must hold WAIT_MAX
// PORTS
//  clk        in  1  clock, rising edge
//  rst        in  1  reset, asynchronous, active-high
//  req_valid  in  1  access request this cycle (sampled only in IDLE)
//  mem_read   in  1  load request
//  mem_write  in  1  store request
//  funct3     in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  addr       in  n  effective address (ALUout)
//  wdata      in  n  store data (rs2)
//  busy       out 1  state != IDLE; core stalls on it
//  done       out 1  one-cycle completion pulse
//  rdata      out n  extended load result; valid with done, held until next load completes
//  misaligned out 1  valid with done: address misaligned for size
//  err        out 1  valid with done: illegal funct3 or ack timeout
//  m_req      out 1  memory request, held until m_ack
//  m_we       out 1  1 = write
//  m_be       out 4  byte enables
//  m_addr     out n  word address {addr[n-1:2],2'b00}
//  m_wdata    out n  lane-aligned store data
//  m_ack      in  1  memory accepted/completed; m_rdata valid same cycle
//  m_rdata    in  n  read word
// BEHAVIOUR
//  Reset (async): state IDLE; busy, done, misaligned, err, m_req, m_we = 0; m_be = 0;
//   rdata, m_addr, m_wdata, wait counter = 0. Reset mid-access drops m_req at once; request is lost.
//  FSM: IDLE -> REQ -> DONE -> IDLE, or IDLE -> DONE (fault).
//  IDLE: accept when req_valid & (mem_read ^ mem_write). Both or neither set: ignored, stay IDLE.
//   Illegal funct3 (011, 110, 111), or store with funct3 100/101: go DONE, err=1, no memory access.
//   Misaligned (H/HU/SH: addr[0]; W/SW: addr[1:0] != 0): go DONE, misaligned=1, no memory access.
//   Otherwise latch addr[1:0], funct3 and direction; drive m_addr/m_be/m_wdata/m_we;
//   clear wait counter; go REQ.
//  Store lanes: SB be=0001<<addr[1:0], m_wdata={4{wdata[7:0]}};
//   SH be=0011<<addr[1:0], m_wdata={2{wdata[15:0]}}; SW be=1111, m_wdata=wdata.
//  Load: m_be = 1111 for all sizes; lane selected after ack.
//  REQ: m_req=1; all m_* outputs stable until ack.
//   m_ack=1: loads register the extracted lane -> rdata
//    (B/BU: m_rdata[8*addr[1:0]+:8]; H/HU: m_rdata[16*addr[1]+:16]; sign-extend B/H, zero-extend BU/HU);
//    go DONE.
//   No ack: counter increments; counter == WAIT_MAX-1 without ack -> go DONE, err=1, rdata unchanged.
//  DONE: done=1 for exactly one cycle with flags; m_req=0; -> IDLE. Flags clear in IDLE.
//  Latency: accept at cycle t, ack at t+1 -> done at t+2 (minimum).
//   A fault gives done at t+1.
//  req_valid while busy: ignored. Stores leave rdata unchanged.
// TESTING
//  1 LW addr=0x100, m_ack at 1st REQ cycle, m_rdata=0xDEADBEEF
//    -> m_addr=0x100, be=1111; done 2 cycles after accept; rdata=0xDEADBEEF
//  2 LB addr=0x103, m_rdata=0x80112233 -> rdata=0xFFFFFF80; LBU same -> 0x00000080;
//    LHU addr=0x102 -> 0x00008011
//  3 SH addr=0x102, wdata=0x0000ABCD -> m_we=1, be=1100, m_wdata=0xABCDABCD; rdata unchanged
//  4 LW addr=0x101 -> misaligned=1 with done 1 cycle after accept, m_req never asserted;
//    funct3=011 -> err=1, no access
//  5 LW, m_ack never asserted -> m_req held 15 cycles, then done with err=1, busy drops next cycle
//  6 SW, rst asserted mid-REQ -> m_req/busy low immediately; new LW after reset completes normally

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I memory-access stage. Takes the ALU result as the
// effective address and runs one load or store per request against a
// word-wide data memory. Raises busy while an access is outstanding and
// reports completion with a one-cycle done pulse plus fault flags.
//
// Memory handshake: while m_req is high, m_we/m_be/m_addr/m_wdata are held
// stable. The memory completes the access by raising m_ack for one cycle;
// on a read, m_rdata must be valid in that same cycle. m_req falls in the
// cycle after m_ack is sampled. If the memory does not respond within
// WAIT_MAX request cycles, the access is abandoned and reported as err.
module load_store_unit #(
  parameter int n        = 32,
  parameter int WAIT_MAX = 15,
  parameter int CW       = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [2:0]   funct3,
  input  logic [n-1:0] addr,
  input  logic [n-1:0] wdata,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] rdata,
  output logic         misaligned,
  output logic         err,
  output logic         m_req,
  output logic         m_we,
  output logic [3:0]   m_be,
  output logic [n-1:0] m_addr,
  output logic [n-1:0] m_wdata,
  input  logic         m_ack,
  input  logic [n-1:0] m_rdata,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         next_state;

  // Request decode
  logic           accept;
  logic           illegal;
  logic           unaligned;

  // Store lane steering
  logic [3:0]     st_be;
  logic [n-1:0]   st_data;

  // Access context captured at accept
  logic [1:0]     lat_off;
  logic [2:0]     lat_funct3;
  logic           lat_load;
  logic [CW-1:0]  wait_cnt;

  // Load lane extraction
  logic [7:0]     ld_byte;
  logic [15:0]    ld_half;
  logic [n-1:0]   ld_ext;

  logic           timeout;

  assign timeout = (wait_cnt == CW'(WAIT_MAX - 1));

  // Classify the incoming request: legality of funct3/direction and alignment.
  always_comb begin
    accept    = req_valid & (mem_read ^ mem_write);
    illegal   = 1'b0;
    unaligned = 1'b0;
    case (funct3)
      3'b011, 3'b110, 3'b111: illegal = 1'b1;
      3'b100, 3'b101:         illegal = mem_write;
      default:                illegal = 1'b0;
    endcase
    case (funct3[1:0])
      2'b01:   unaligned = addr[0];
      2'b10:   unaligned = |addr[1:0];
      default: unaligned = 1'b0;
    endcase
  end

  // Byte enables and replicated store data; loads always fetch the full word.
  always_comb begin
    st_be   = 4'b1111;
    st_data = '0;
    if (mem_write) begin
      case (funct3[1:0])
        2'b00: begin
          st_be   = 4'b0001 << addr[1:0];
          st_data = {4{wdata[7:0]}};
        end
        2'b01: begin
          st_be   = 4'b0011 << addr[1:0];
          st_data = {2{wdata[15:0]}};
        end
        default: begin
          st_be   = 4'b1111;
          st_data = wdata;
        end
      endcase
    end
  end

  // Pick the addressed lane out of the returned word and extend it.
  always_comb begin
    ld_byte = m_rdata[8*lat_off +: 8];
    ld_half = m_rdata[16*lat_off[1] +: 16];
    case (lat_funct3)
      3'b000:  ld_ext = {{(n-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {{(n-8){1'b0}}, ld_byte};
      3'b001:  ld_ext = {{(n-16){ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {{(n-16){1'b0}}, ld_half};
      default: ld_ext = m_rdata;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state and state-decoded outputs.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    m_req      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = (illegal | unaligned) ? DONE : REQ;
        end
      end
      REQ: begin
        busy  = 1'b1;
        m_req = 1'b1;
        if (m_ack || timeout) begin
          next_state = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign dbg_state = state;

  // Datapath: capture the access at accept, count wait cycles, register load
  // data on ack, and set the fault flags that accompany done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata      <= '0;
      misaligned <= 1'b0;
      err        <= 1'b0;
      m_we       <= 1'b0;
      m_be       <= 4'b0000;
      m_addr     <= '0;
      m_wdata    <= '0;
      lat_off    <= 2'b00;
      lat_funct3 <= 3'b000;
      lat_load   <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          misaligned <= 1'b0;
          err        <= 1'b0;
          if (accept) begin
            if (illegal) begin
              err <= 1'b1;
            end else if (unaligned) begin
              misaligned <= 1'b1;
            end else begin
              lat_off    <= addr[1:0];
              lat_funct3 <= funct3;
              lat_load   <= mem_read;
              m_we       <= mem_write;
              m_be       <= st_be;
              m_addr     <= {addr[n-1:2], 2'b00};
              m_wdata    <= st_data;
              wait_cnt   <= '0;
            end
          end
        end
        REQ: begin
          if (m_ack) begin
            if (lat_load) begin
              rdata <= ld_ext;
            end
          end else if (timeout) begin
            err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
          misaligned <= 1'b0;
          err        <= 1'b0;
        end
        default: begin
          misaligned <= 1'b0;
          err        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed load/store/fault vectors, a memory
// responder that checks each request and acks after a chosen delay, and a
// done monitor that compares each completion against an expected queue.
`timescale 1ns/1ps
module tb_load_store_unit;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        req_valid;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        misaligned;
  logic        err;
  logic        m_req;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ack = 1'b0;
  logic [31:0] m_rdata = 32'h0;
  logic [1:0]  dbg_state;

  load_store_unit #(.n(32), .WAIT_MAX(15), .CW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .rdata      (rdata),
    .misaligned (misaligned),
    .err        (err),
    .m_req      (m_req),
    .m_we       (m_we),
    .m_be       (m_be),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_ack      (m_ack),
    .m_rdata    (m_rdata),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          passes = 0;
  logic [33:0] exp_q[$];   // {rdata, misaligned, err}
  logic [68:0] req_q[$];   // {we, be, addr, wdata}
  int          ack_delay = -1;
  logic [31:0] resp_data = 32'h0;
  int          req_cycles = 0;
  bit          in_req = 1'b0;
  logic [68:0] req_e;
  logic [33:0] done_e;

  task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- memory responder ----------------
  // Checks the request on its first cycle, then acks after ack_delay cycles
  // (never if ack_delay < 0). req_cycles holds the length of the last request.
  always @(negedge clk) begin
    if (m_req === 1'b1) begin
      if (!in_req) begin
        in_req     = 1'b1;
        req_cycles = 0;
        if (req_q.size() == 0) begin
          check("unexpected_m_req", 69'd1, 69'd0);
        end else begin
          req_e = req_q.pop_front();
          check("m_we", {68'd0, m_we}, {68'd0, req_e[68]});
          check("m_be", {65'd0, m_be}, {65'd0, req_e[67:64]});
          check("m_addr", {37'd0, m_addr}, {37'd0, req_e[63:32]});
          if (req_e[68]) check("m_wdata", {37'd0, m_wdata}, {37'd0, req_e[31:0]});
        end
      end
      m_ack   = (ack_delay >= 0) && (req_cycles == ack_delay);
      m_rdata = resp_data;
      req_cycles++;
    end else begin
      in_req = 1'b0;
      m_ack  = 1'b0;
    end
  end

  // ---------------- done monitor ----------------
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 69'd1, 69'd0);
      end else begin
        done_e = exp_q.pop_front();
        check("rdata", {37'd0, rdata}, {37'd0, done_e[33:2]});
        check("misaligned", {68'd0, misaligned}, {68'd0, done_e[1]});
        check("err", {68'd0, err}, {68'd0, done_e[0]});
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input string name, input logic rd, input logic wr,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       input int delay, input logic [31:0] word,
                       input logic has_req, input logic [3:0] be, input logic [31:0] exp_wd,
                       input logic [31:0] exp_rd, input logic mis, input logic er,
                       input int lat, input int req_len);
    int c;
    ack_delay = delay;
    resp_data = word;
    if (has_req) req_q.push_back({wr, be, a[31:2], 2'b00, exp_wd});
    exp_q.push_back({exp_rd, mis, er});
    @(negedge clk);
    req_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    c = 1;
    while (done !== 1'b1 && c < 40) begin
      @(negedge clk);
      c++;
    end
    check({name, " latency"}, 69'(c), 69'(lat));
    @(negedge clk);
    check({name, " done_pulse_busy"}, {67'd0, done, busy}, 69'd0);
    if (req_len >= 0) check({name, " req_len"}, 69'(req_cycles), 69'(req_len));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    repeat (2) @(negedge clk);
    check("reset busy/done/m_req", {66'd0, busy, done, m_req}, 69'd0);
    check("reset flags/m_we", {66'd0, misaligned, err, m_we}, 69'd0);
    check("reset m_be", {65'd0, m_be}, 69'd0);
    check("reset m_addr", {37'd0, m_addr}, 69'd0);
    check("reset m_wdata", {37'd0, m_wdata}, 69'd0);
    check("reset rdata", {37'd0, rdata}, 69'd0);
    check("reset state", {67'd0, dbg_state}, 69'd0);
    rst = 1'b0;

    // Loads
    issue("lw_100",   1, 0, 3'b010, 32'h100, 0, 0, 32'hDEADBEEF, 1, 4'hF, 0, 32'hDEADBEEF, 0, 0, 2, 1);
    issue("lb_103",   1, 0, 3'b000, 32'h103, 0, 0, 32'h80112233, 1, 4'hF, 0, 32'hFFFFFF80, 0, 0, 2, 1);
    issue("lbu_103",  1, 0, 3'b100, 32'h103, 0, 0, 32'h80112233, 1, 4'hF, 0, 32'h00000080, 0, 0, 2, 1);
    issue("lhu_102",  1, 0, 3'b101, 32'h102, 0, 0, 32'h80112233, 1, 4'hF, 0, 32'h00008011, 0, 0, 2, 1);
    issue("lh_102",   1, 0, 3'b001, 32'h102, 0, 0, 32'h80112233, 1, 4'hF, 0, 32'hFFFF8011, 0, 0, 2, 1);
    issue("lb_101_d3",1, 0, 3'b000, 32'h101, 0, 3, 32'h80112233, 1, 4'hF, 0, 32'h00000022, 0, 0, 5, 4);
    issue("lh_100",   1, 0, 3'b001, 32'h100, 0, 0, 32'h80112233, 1, 4'hF, 0, 32'h00002233, 0, 0, 2, 1);

    // Stores (rdata keeps the last load value)
    issue("sh_102",   0, 1, 3'b001, 32'h102, 32'h0000ABCD, 0, 0, 1, 4'hC, 32'hABCDABCD, 32'h00002233, 0, 0, 2, 1);
    issue("sb_101_d1",0, 1, 3'b000, 32'h101, 32'h12345678, 1, 0, 1, 4'h2, 32'h78787878, 32'h00002233, 0, 0, 3, 2);
    issue("sw_104",   0, 1, 3'b010, 32'h104, 32'hCAFEF00D, 0, 0, 1, 4'hF, 32'hCAFEF00D, 32'h00002233, 0, 0, 2, 1);

    // Faults: no memory access, done one cycle after accept
    issue("lw_101_mis", 1, 0, 3'b010, 32'h101, 0, 0, 0, 0, 4'h0, 0, 32'h00002233, 1, 0, 1, -1);
    issue("lw_102_mis", 1, 0, 3'b010, 32'h102, 0, 0, 0, 0, 4'h0, 0, 32'h00002233, 1, 0, 1, -1);
    issue("lh_103_mis", 1, 0, 3'b001, 32'h103, 0, 0, 0, 0, 4'h0, 0, 32'h00002233, 1, 0, 1, -1);
    issue("lhu_101_mis",1, 0, 3'b101, 32'h101, 0, 0, 0, 0, 4'h0, 0, 32'h00002233, 1, 0, 1, -1);
    issue("f3_011_err", 1, 0, 3'b011, 32'h100, 0, 0, 0, 0, 4'h0, 0, 32'h00002233, 0, 1, 1, -1);
    issue("s_f3_100_err",0,1, 3'b100, 32'h100, 0, 0, 0, 0, 4'h0, 0, 32'h00002233, 0, 1, 1, -1);
    issue("s_f3_110_err",0,1, 3'b110, 32'h100, 0, 0, 0, 0, 4'h0, 0, 32'h00002233, 0, 1, 1, -1);

    // Both / neither direction set: ignored
    @(negedge clk);
    req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b1; funct3 = 3'b010; addr = 32'h100;
    @(negedge clk);
    check("ignored_both busy", {68'd0, busy}, 69'd0);
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    check("ignored_neither busy", {68'd0, busy}, 69'd0);
    req_valid = 1'b0;

    // Timeout: m_req held 15 cycles, then err; rdata unchanged
    issue("lw_timeout", 1, 0, 3'b010, 32'h108, 0, -1, 32'h11111111, 1, 4'hF, 0, 32'h00002233, 0, 1, 16, 15);

    // Reset in the middle of a store request
    ack_delay = -1;
    req_q.push_back({1'b1, 4'hF, 32'h200, 32'h55AA55AA});
    @(negedge clk);
    req_valid = 1'b1; mem_write = 1'b1; funct3 = 3'b010; addr = 32'h200; wdata = 32'h55AA55AA;
    @(negedge clk);
    req_valid = 1'b0; mem_write = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst m_req", {68'd0, m_req}, 69'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst m_req/busy", {67'd0, m_req, busy}, 69'd0);
    check("mid_rst rdata", {37'd0, rdata}, 69'd0);
    @(negedge clk);
    rst = 1'b0;
    issue("lw_after_rst", 1, 0, 3'b010, 32'h10C, 0, 0, 32'h0BADCAFE, 1, 4'hF, 0, 32'h0BADCAFE, 0, 0, 2, 1);

    repeat (2) @(negedge clk);
    check("exp_q drained", 69'(exp_q.size()), 69'd0);
    check("req_q drained", 69'(req_q.size()), 69'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
